// File: rtl/i2s_tx_frame_ctrl_if.sv
// Sample-pair source interface for the I2S transmit frame controller.
// The source offers a left/right pair with s_valid; the controller pulses
// s_ready for one cycle at each frame boundary to take the pair.
interface i2s_tx_frame_ctrl_if #(
  parameter int DATA_W = 24
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  // Sample source side.
  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  // Frame controller side.
  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/i2s_tx_frame_ctrl.sv
// I2S transmit frame controller.
// Divides aud_mclk down to SCLK, runs a 64-slot frame (32 slots per channel),
// takes one left/right pair per frame at the frame boundary and shifts it out
// MSB first with the standard one-SCLK I2S delay. Missing pairs are reported
// as underflows: the frame goes out as zeros, irq is set and a saturating
// counter advances.
// aud_mrst asserts asynchronously; its release is expected to be synchronous
// to aud_mclk already.
module i2s_tx_frame_ctrl #(
  parameter int DATA_W = 24,
  parameter int DIV_W  = 8
) (
  input  logic               aud_mclk,
  input  logic               aud_mrst,
  input  logic               enable,
  input  logic [DIV_W-1:0]   sclk_div,
  input  logic               irq_clr,
  i2s_tx_frame_ctrl_if.slave s_if,
  output logic               sclk_out,
  output logic               lrclk_out,
  output logic               sdata_0_out,
  output logic               irq,
  output logic [7:0]         underflow_cnt,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] SLOT_LAST  = 6'd63;
  localparam logic [5:0] SLOT_RIGHT = 6'd31;  // tick out of 31 lands in slot 32

  state_t             state_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [DIV_W-1:0]   div_lat_q;
  logic [5:0]         slot_q;
  logic [31:0]        shift_q;
  logic [DATA_W-1:0]  hold_r_q;

  logic               run;
  logic               div_hit;
  logic               fall_tick;
  logic               boundary;
  logic               take;
  logic               underflow;
  logic               right_load;
  logic [5:0]         slot_nxt;
  logic [DIV_W-1:0]   div_eff;
  logic [31:0]        shift_src;

  // Places a sample in a 32-bit slot word: one leading zero for the I2S
  // delay, the sample MSB first, zero padding below it.
  function automatic logic [31:0] frame_word(input logic [DATA_W-1:0] smp);
    logic [31:0] w;
    w = '0;
    w[30 -: DATA_W] = smp;
    return w;
  endfunction

  assign run        = (state_q == ST_RUN);
  assign div_hit    = (div_cnt_q == (div_lat_q - DIV_W'(1)));
  assign fall_tick  = run && div_hit && sclk_out;
  assign boundary   = fall_tick && (slot_q == SLOT_LAST);
  assign right_load = fall_tick && (slot_q == SLOT_RIGHT);
  assign slot_nxt   = slot_q + 6'd1;
  assign div_eff    = (sclk_div == '0) ? DIV_W'(1) : sclk_div;

  // The pair is only offered at a boundary that continues the stream; a
  // boundary that ends the run offers nothing and cannot underflow.
  assign s_if.s_ready = boundary && enable;
  assign take         = s_if.s_ready && s_if.s_valid;
  assign underflow    = s_if.s_ready && !s_if.s_valid;

  assign busy = run;

  // Select what the shifter holds before this tick's bit is taken from it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    shift_src = shift_q;
    if (boundary) begin
      shift_src = take ? frame_word(s_if.s_left) : '0;
    end else if (right_load) begin
      shift_src = frame_word(hold_r_q);
    end
  end

  // Run/idle FSM with SCLK divider, slot counter and serializer.
  always_ff @(posedge aud_mclk or negedge aud_mrst) begin
    if (!aud_mrst) begin
      // NOTE: the shifter and right-channel holding register are data storage
      // but are reset anyway, so a frame cut short by reset can never leak
      // stale sample bits into the next run.
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      div_lat_q   <= '0;
      slot_q      <= '0;
      shift_q     <= '0;
      hold_r_q    <= '0;
      sclk_out    <= 1'b0;
      lrclk_out   <= 1'b0;
      sdata_0_out <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the values from before this edge.
      unique case (state_q)
        ST_IDLE: begin
          sclk_out    <= 1'b0;
          lrclk_out   <= 1'b0;
          sdata_0_out <= 1'b0;
          if (enable) begin
            state_q   <= ST_RUN;
            div_cnt_q <= '0;
            div_lat_q <= div_eff;
            slot_q    <= SLOT_LAST;
          end
        end

        ST_RUN: begin
          if (div_hit) begin
            div_cnt_q <= '0;
            sclk_out  <= ~sclk_out;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end

          if (fall_tick) begin
            slot_q <= slot_nxt;
            if (boundary && !enable) begin
              // The frame has completed slot 63; park all I2S lines low.
              state_q     <= ST_IDLE;
              sclk_out    <= 1'b0;
              lrclk_out   <= 1'b0;
              sdata_0_out <= 1'b0;
              shift_q     <= '0;
              hold_r_q    <= '0;
            end else begin
              lrclk_out   <= slot_nxt[5];
              sdata_0_out <= shift_src[31];
              shift_q     <= shift_src << 1;
              if (boundary) begin
                // A new divider setting only ever starts on a fresh frame.
                div_lat_q <= div_eff;
                hold_r_q  <= take ? s_if.s_right : '0;
              end
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky underflow interrupt and saturating missed-frame counter; a new
  // underflow wins over a simultaneous clear.
  always_ff @(posedge aud_mclk or negedge aud_mrst) begin
    if (!aud_mrst) begin
      irq           <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (underflow) begin
        irq <= 1'b1;
        if (underflow_cnt != 8'hFF) begin
          underflow_cnt <= underflow_cnt + 8'd1;
        end
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Directed testbench for i2s_tx_frame_ctrl.
// Outputs are sampled 1 ns after each rising aud_mclk edge. A falling SCLK
// edge seen between two samples marks a slot; the bench tracks the slot number
// itself and compares captured frames against hand-derived bit patterns.
module tb_i2s_tx_frame_ctrl;

  localparam int DATA_W = 24;
  localparam int DIV_W  = 8;
  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  logic              aud_mclk;
  logic              aud_mrst;
  logic              enable;
  logic [DIV_W-1:0]  sclk_div;
  logic              irq_clr;
  logic              sclk_out;
  logic              lrclk_out;
  logic              sdata_0_out;
  logic              irq;
  logic [7:0]        underflow_cnt;
  logic              busy;

  i2s_tx_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();

  i2s_tx_frame_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .aud_mclk      (aud_mclk),
    .aud_mrst      (aud_mrst),
    .enable        (enable),
    .sclk_div      (sclk_div),
    .irq_clr       (irq_clr),
    .s_if          (bus),
    .sclk_out      (sclk_out),
    .lrclk_out     (lrclk_out),
    .sdata_0_out   (sdata_0_out),
    .irq           (irq),
    .underflow_cnt (underflow_cnt),
    .busy          (busy)
  );

  initial aud_mclk = 1'b0;
  always #5 aud_mclk = ~aud_mclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fall_cnt = 0;
  int          ready_cnt = 0;
  bit          fell     = 1'b0;
  bit          sclk_prev = 1'b0;
  bit          rdy_now  = 1'b0;
  bit          rdy_last = 1'b0;
  logic [5:0]  tb_slot  = 6'd0;
  logic [63:0] cap_data;
  logic [63:0] cap_lr;
  int          cap_t [64];
  logic        cap_rdy_b;
  logic        cap_irq_b;
  logic [7:0]  cap_ucnt_b;
  int          t0_prev;

  // Expected serial data indexed by slot: slot 0 and 32 are the delay bits,
  // samples follow MSB first, everything after the LSB is zero.
  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] e;
    e = '0;
    for (int s = 1; s <= 24; s++) begin
      e[s]      = l[24 - s];
      e[32 + s] = r[24 - s];
    end
    return e;
  endfunction

  task automatic abort_timeout(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s_timeout: no event within 2000 cycles, expected one", what);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "bench stopped on timeout");
  endtask

  task automatic step();
    @(posedge aud_mclk);
    #1;
    cyc++;
    fell      = sclk_prev && !sclk_out;
    sclk_prev = sclk_out;
    if (fell) begin
      tb_slot = tb_slot + 6'd1;
      fall_cnt++;
    end
    rdy_last = rdy_now;
    rdy_now  = bus.s_ready;
    if (bus.s_ready) ready_cnt++;
  endtask

  task automatic wait_fall();
    for (int i = 0; i < 2000; i++) begin
      step();
      if (fell) return;
    end
    abort_timeout("sclk_fall");
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      step();
      if (rdy_now) return;
    end
    abort_timeout("s_ready");
  endtask

  task automatic wait_slot(input logic [5:0] target);
    do wait_fall(); while (tb_slot != target);
  endtask

  // Captures slots 0..63 of one frame, starting at the next boundary.
  task automatic capture_frame(input logic valid_at_b, input int chg_slot,
                               input logic [7:0] chg_div);
    bus.s_valid = valid_at_b;
    ready_cnt   = 0;
    for (int s = 0; s < 64; s++) begin
      wait_fall();
      cap_data[s] = sdata_0_out;
      cap_lr[s]   = lrclk_out;
      cap_t[s]    = cyc;
      if (s == 0) begin
        cap_rdy_b   = rdy_last;
        cap_irq_b   = irq;
        cap_ucnt_b  = underflow_cnt;
        bus.s_valid = 1'b1;
      end
      if (s == chg_slot) sclk_div = chg_div;
    end
  endtask

  task automatic test_reset();
    aud_mrst = 1'b0; enable = 1'b0; sclk_div = 8'd2; irq_clr = 1'b0;
    bus.s_valid = 1'b0; bus.s_left = '0; bus.s_right = '0;
    repeat (3) @(posedge aud_mclk);
    #1;
    n_checks++;
    if ({sclk_out, lrclk_out, sdata_0_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_i2s_lines: got %b expected 000", {sclk_out, lrclk_out, sdata_0_out});
    end
    n_checks++;
    if ({bus.s_ready, irq, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready_irq_busy: got %b expected 000", {bus.s_ready, irq, busy});
    end
    n_checks++;
    if (underflow_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_underflow_cnt: got %0d expected 0", underflow_cnt);
    end
    aud_mrst = 1'b1;
    step(); step();
    n_checks++;
    if ({busy, sclk_out} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_release: got busy,sclk=%b expected 00", {busy, sclk_out});
    end
  endtask

  task automatic test_basic();
    sclk_div = 8'd2; bus.s_left = 24'hA5A5A5; bus.s_right = 24'h5A5A5A;
    enable = 1'b1; tb_slot = 6'd63;
    step();
    n_checks++;
    if ({busy, sclk_out} !== 2'b10) begin
      n_fail++; $display("FAIL run_entry: got busy,sclk=%b expected 10", {busy, sclk_out});
    end
    capture_frame(1'b1, -1, 8'd0);
    n_checks++;
    if (cap_data !== exp_frame(24'hA5A5A5, 24'h5A5A5A)) begin
      n_fail++; $display("FAIL basic_data: got %h expected %h", cap_data, exp_frame(24'hA5A5A5, 24'h5A5A5A));
    end
    n_checks++;
    if (cap_lr !== LR_EXP) begin
      n_fail++; $display("FAIL basic_lrclk: got %h expected %h", cap_lr, LR_EXP);
    end
    n_checks++;
    if (cap_t[1] - cap_t[0] !== 4) begin
      n_fail++; $display("FAIL basic_sclk_period: got %0d expected 4", cap_t[1] - cap_t[0]);
    end
    n_checks++;
    if (cap_t[63] - cap_t[0] !== 252) begin
      n_fail++; $display("FAIL basic_slot_span: got %0d expected 252", cap_t[63] - cap_t[0]);
    end
    n_checks++;
    if ({cap_rdy_b, ready_cnt == 1} !== 2'b11) begin
      n_fail++; $display("FAIL basic_s_ready: got at_boundary=%b count=%0d expected 1 and 1", cap_rdy_b, ready_cnt);
    end
    n_checks++;
    if ({cap_irq_b, cap_ucnt_b} !== 9'd0) begin
      n_fail++; $display("FAIL basic_no_underflow: got irq=%b cnt=%0d expected 0 and 0", cap_irq_b, cap_ucnt_b);
    end
    t0_prev = cap_t[0];
  endtask

  task automatic test_underflow();
    capture_frame(1'b0, -1, 8'd0);
    n_checks++;
    if (cap_t[0] - t0_prev !== 256) begin
      n_fail++; $display("FAIL frame_length: got %0d expected 256", cap_t[0] - t0_prev);
    end
    n_checks++;
    if (cap_data !== 64'd0) begin
      n_fail++; $display("FAIL underflow_data: got %h expected 0", cap_data);
    end
    n_checks++;
    if (cap_lr !== LR_EXP) begin
      n_fail++; $display("FAIL underflow_lrclk: got %h expected %h", cap_lr, LR_EXP);
    end
    n_checks++;
    if ({cap_irq_b, cap_ucnt_b} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL underflow_flag: got irq=%b cnt=%0d expected 1 and 1", cap_irq_b, cap_ucnt_b);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_sticky: got %b expected 1", irq);
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    n_checks++;
    if ({irq, underflow_cnt} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL irq_clr: got irq=%b cnt=%0d expected 0 and 1", irq, underflow_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int f0;
    wait_slot(6'd10);
    enable    = 1'b0;
    ready_cnt = 0;
    f0        = fall_cnt;
    wait_slot(6'd0);
    n_checks++;
    if (fall_cnt - f0 !== 54) begin
      n_fail++; $display("FAIL drop_completes_frame: got %0d falls expected 54", fall_cnt - f0);
    end
    n_checks++;
    if ({busy, ready_cnt != 0} !== 2'b00) begin
      n_fail++; $display("FAIL drop_boundary: got busy=%b ready_count=%0d expected 0 and 0", busy, ready_cnt);
    end
    step();
    n_checks++;
    if ({sclk_out, lrclk_out, sdata_0_out} !== 3'b000) begin
      n_fail++; $display("FAIL drop_i2s_lines: got %b expected 000", {sclk_out, lrclk_out, sdata_0_out});
    end
    f0 = fall_cnt;
    repeat (10) step();
    n_checks++;
    if ({fall_cnt != f0, sclk_out, busy} !== 3'b000) begin
      n_fail++; $display("FAIL drop_stays_idle: got falls=%0d sclk=%b busy=%b expected 0,0,0", fall_cnt - f0, sclk_out, busy);
    end
  endtask

  task automatic test_div0();
    int ta;
    sclk_div = 8'd0; bus.s_left = 24'h800001; bus.s_right = 24'h7FFFFE;
    enable = 1'b1; tb_slot = 6'd63;
    capture_frame(1'b1, 20, 8'd4);
    n_checks++;
    if (cap_data !== exp_frame(24'h800001, 24'h7FFFFE)) begin
      n_fail++; $display("FAIL div0_data: got %h expected %h", cap_data, exp_frame(24'h800001, 24'h7FFFFE));
    end
    n_checks++;
    if (cap_t[1] - cap_t[0] !== 2) begin
      n_fail++; $display("FAIL div0_period: got %0d expected 2", cap_t[1] - cap_t[0]);
    end
    n_checks++;
    if (cap_t[63] - cap_t[0] !== 126) begin
      n_fail++; $display("FAIL div_change_midframe: got span %0d expected 126", cap_t[63] - cap_t[0]);
    end
    n_checks++;
    if (cap_rdy_b !== 1'b1) begin
      n_fail++; $display("FAIL div0_s_ready: got %b expected 1", cap_rdy_b);
    end
    ta = cap_t[0];
    capture_frame(1'b1, -1, 8'd0);
    n_checks++;
    if (cap_t[0] - ta !== 128) begin
      n_fail++; $display("FAIL div0_frame_length: got %0d expected 128", cap_t[0] - ta);
    end
    n_checks++;
    if ({cap_t[1] - cap_t[0] == 8, cap_t[63] - cap_t[0] == 504} !== 2'b11) begin
      n_fail++; $display("FAIL div4_period: got %0d span %0d expected 8 span 504", cap_t[1] - cap_t[0], cap_t[63] - cap_t[0]);
    end
    n_checks++;
    if (cap_data !== exp_frame(24'h800001, 24'h7FFFFE)) begin
      n_fail++; $display("FAIL div4_data: got %h expected %h", cap_data, exp_frame(24'h800001, 24'h7FFFFE));
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    enable = 1'b0;
    wait_fall();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_before_saturate: got busy=%b expected 0", busy);
    end
    sclk_div = 8'd1; bus.s_valid = 1'b0; enable = 1'b1; tb_slot = 6'd63;
    wait_ready();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    n_checks++;
    if ({irq, underflow_cnt} !== {1'b1, 8'd2}) begin
      n_fail++; $display("FAIL clr_vs_underflow: got irq=%b cnt=%0d expected 1 and 2", irq, underflow_cnt);
    end
    for (int i = 2; i <= 300; i++) begin
      wait_slot(6'd0);
      exp_cnt = (1 + i > 255) ? 255 : 1 + i;
      n_checks++;
      if (underflow_cnt !== exp_cnt[7:0]) begin
        n_fail++; $display("FAIL underflow_cnt_%0d: got %0d expected %0d", i, underflow_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bus.s_valid = 1'b1; bus.s_left = 24'h123456; bus.s_right = 24'hFEDCBA;
    wait_slot(6'd40);
    n_checks++;
    if (lrclk_out !== 1'b1) begin
      n_fail++; $display("FAIL slot40_lrclk: got %b expected 1", lrclk_out);
    end
    #2;
    aud_mrst = 1'b0;
    #1;
    n_checks++;
    if ({sclk_out, lrclk_out, sdata_0_out, bus.s_ready, irq, busy} !== 6'd0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %b expected 000000",
                         {sclk_out, lrclk_out, sdata_0_out, bus.s_ready, irq, busy});
    end
    n_checks++;
    if (underflow_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", underflow_cnt);
    end
    repeat (2) @(posedge aud_mclk);
    #1;
    aud_mrst  = 1'b1;
    sclk_prev = 1'b0;
    rdy_now   = 1'b0;
    tb_slot   = 6'd63;
    step();
    n_checks++;
    if ({busy, sclk_out} !== 2'b10) begin
      n_fail++; $display("FAIL restart_entry: got busy,sclk=%b expected 10", {busy, sclk_out});
    end
    capture_frame(1'b1, -1, 8'd0);
    n_checks++;
    if (cap_data !== exp_frame(24'h123456, 24'hFEDCBA)) begin
      n_fail++; $display("FAIL restart_data: got %h expected %h", cap_data, exp_frame(24'h123456, 24'hFEDCBA));
    end
    n_checks++;
    if ({cap_t[1] - cap_t[0] == 2, cap_rdy_b, cap_irq_b} !== 3'b110) begin
      n_fail++; $display("FAIL restart_frame: got period=%0d ready=%b irq=%b expected 2,1,0",
                         cap_t[1] - cap_t[0], cap_rdy_b, cap_irq_b);
    end
    n_checks++;
    if (cap_ucnt_b !== 8'd0) begin
      n_fail++; $display("FAIL restart_cnt: got %0d expected 0", cap_ucnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_enable_drop();
    test_div0();
    test_saturate();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
